// File: rtl/mmio_kbd_responder_if.sv
// rtl/mmio_kbd_responder_if.sv - CPU data-bus bundle for the memory-mapped PS/2 keyboard responder
interface mmio_kbd_responder_if;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        hit;

    modport master (output ce, output we, output addr, output sel, output data_i,
                    input data_o, input hit);
    modport slave  (input ce, input we, input addr, input sel, input data_i,
                    output data_o, output hit);
endinterface

// File: rtl/mmio_kbd_responder.sv
// rtl/mmio_kbd_responder.sv - PS/2 keyboard receiver with scan-code FIFO behind an 8-byte MMIO window
// Optional break-code filtering is built when KBD_BREAK_FILTER_EN is defined.
module mmio_kbd_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0020_0000,
    parameter int          FIFO_AW   = 4,
    parameter int          TIMEOUT   = 50000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    mmio_kbd_responder_if.slave   bus,
    input  logic                  i_ps2_clk,
    input  logic                  i_ps2_data,
    output logic                  o_irq
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_CHECK} state_t;

    state_t             r_state, w_next;
    logic [1:0]         r_ps2c_sync, r_ps2d_sync;
    logic               r_ps2c_prev;
    logic [9:0]         r_shift;
    logic [3:0]         r_bitcnt;
    logic [TW-1:0]      r_tcnt;
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_ovf, r_perr, r_irq, r_rd_sel_d;
    logic [8:0]         r_hold;

    logic        w_fall, w_ps2d, w_check, w_valid, w_frame_ok, w_push;
    logic        w_full, w_empty, w_do_push, w_do_pop, w_pop;
    logic [31:0] w_off;
    logic        w_hit, w_rd_sel, w_wr_status;
    logic [31:0] w_status;
    logic        w_unused;

    assign w_ps2d = r_ps2d_sync[1];
    assign w_fall = r_ps2c_prev & ~r_ps2c_sync[1];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ps2c_sync <= 2'b00;
            r_ps2d_sync <= 2'b00;
            r_ps2c_prev <= 1'b0;
        end else begin
            r_ps2c_sync <= {r_ps2c_sync[0], i_ps2_clk};
            r_ps2d_sync <= {r_ps2d_sync[0], i_ps2_data};
            r_ps2c_prev <= r_ps2c_sync[1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_fall && !w_ps2d) w_next = ST_SHIFT;
            ST_SHIFT: begin
                if (w_fall && r_bitcnt == 4'd9)          w_next = ST_CHECK;
                else if (!w_fall && r_tcnt == TW'(TIMEOUT)) w_next = ST_IDLE;
            end
            ST_CHECK: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Bits enter at the top so that after ten shifts d0 sits in bit 0 and stop in bit 9.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_tcnt   <= '0;
        end else if (r_state == ST_SHIFT) begin
            if (w_fall) begin
                r_shift  <= {w_ps2d, r_shift[9:1]};
                r_bitcnt <= r_bitcnt + 4'd1;
                r_tcnt   <= '0;
            end else begin
                r_tcnt   <= r_tcnt + TW'(1);
            end
        end else begin
            r_bitcnt <= '0;
            r_tcnt   <= '0;
        end
    end

    assign w_check    = (r_state == ST_CHECK);
    assign w_valid    = r_shift[9] & (^r_shift[8:0]);
    assign w_frame_ok = w_check & w_valid;

`ifdef KBD_BREAK_FILTER_EN
    logic r_pending;
    logic w_is_f0, w_is_e0;
    assign w_is_f0 = (r_shift[7:0] == 8'hF0);
    assign w_is_e0 = (r_shift[7:0] == 8'hE0);
    // F0 arms the filter; the following non-prefix byte (the break code) is swallowed.
    assign w_push  = w_frame_ok & ~w_is_f0 & (w_is_e0 | ~r_pending);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)                       r_pending <= 1'b0;
        else if (w_frame_ok && w_is_f0)   r_pending <= 1'b1;
        else if (w_frame_ok && !w_is_e0)  r_pending <= 1'b0;
    end
`else
    assign w_push = w_frame_ok;
`endif

    assign w_full    = (r_count == (FIFO_AW + 1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_push = w_push & ~w_full;
    assign w_do_pop  = w_pop & ~w_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= r_shift[7:0];
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

    assign w_off       = bus.addr - BASE_ADDR;
    assign w_hit       = bus.ce && (w_off < 32'd8);
    assign w_rd_sel    = w_hit & ~bus.we & ~bus.addr[2];
    assign w_pop       = w_rd_sel & ~r_rd_sel_d;
    assign w_wr_status = w_hit & bus.we & bus.addr[2] & bus.sel[0];

    // The popped word is latched so a long read keeps showing the byte it consumed.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rd_sel_d <= 1'b0;
            r_hold     <= '0;
            r_ovf      <= 1'b0;
            r_perr     <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_rd_sel_d <= w_rd_sel;
            if (w_pop) r_hold <= w_empty ? 9'd0 : {1'b1, r_mem[r_rd_ptr]};
            if (w_push && w_full)                     r_ovf <= 1'b1;
            else if (w_wr_status && bus.data_i[2])    r_ovf <= 1'b0;
            if (w_check && !w_valid)                  r_perr <= 1'b1;
            else if (w_wr_status && bus.data_i[3])    r_perr <= 1'b0;
            r_irq <= ~w_empty;
        end
    end

    assign w_status = {16'd0, 8'(r_count), 4'd0, r_perr, r_ovf, w_full, ~w_empty};

    always_comb begin
        bus.data_o = 32'd0;
        if (w_hit) begin
            if (bus.addr[2])                 bus.data_o = w_status;
            else if (w_rd_sel && r_rd_sel_d) bus.data_o = {23'd0, r_hold};
            else if (!w_empty)               bus.data_o = {23'd0, 1'b1, r_mem[r_rd_ptr]};
        end
    end

    assign bus.hit  = w_hit;
    assign o_irq    = r_irq;
    assign w_unused = &{1'b0, bus.sel[3:1], bus.data_i[31:4], bus.data_i[1:0]};
endmodule

// File: doc/mmio_kbd_responder.md
Name: mmio_kbd_responder

Overview:
- PS/2 keyboard receiver exposed as a memory-mapped responder on the CPU data bus (ce/we/addr/sel/data).
- Deserialises PS/2 frames, validates them, and buffers scan codes in a FIFO.
- Returns register data to the CPU read-data mux alongside the video RAM and data RAM.
- Runs on the 50 MHz system clock; the CPU may hold a bus request for several cycles.

Parameters:
- BASE_ADDR, 32'h0020_0000, byte address of register window; window is 8 bytes.
- FIFO_AW, 4, log2 of FIFO depth (default 16 entries).
- TIMEOUT, 50000, clk cycles without a PS/2 falling edge before a partial frame is discarded.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  bus chip enable.
- we  in  1  bus write enable.
- addr  in  32  bus byte address.
- sel  in  4  bus byte lanes.
- data_i  in  32  bus write data.
- data_o  out  32  read data; combinational from addr and registers.
- hit  out  1  addr lies inside the window; used by the top-level read-data mux.
- ps2_clk  in  1  raw PS/2 clock (asynchronous).
- ps2_data  in  1  raw PS/2 data (asynchronous).
- irq  out  1  high while the FIFO is non-empty.

Behaviour:
- Reset: all state cleared; FIFO empty; sticky flags 0; irq=0. Since data_o is combinational, it reads 0 except STATUS reads, which reflect the cleared state.
- Input sync: ps2_clk and ps2_data each pass through a 2-flop synchroniser. A falling edge is the synchronised clock going 1 then 0 on consecutive cycles.
- Receive FSM states: IDLE, SHIFT, CHECK.
  - IDLE -> SHIFT on a falling edge with data=0 (start bit). A falling edge with data=1 is ignored.
  - SHIFT samples one bit per falling edge, LSB first: 8 data bits, then parity, then stop.
  - After the stop bit, go to CHECK for 1 cycle.
- CHECK: frame is valid iff the 9-bit odd-parity check holds and stop=1. A valid frame pushes the byte. Otherwise set PERR and push nothing. Then return to IDLE.
- Timeout: in SHIFT, a counter increments each cycle and clears on each falling edge. When it reaches TIMEOUT, return to IDLE with no push and no flag.
- FIFO:
  - Circular buffer of depth 2^FIFO_AW; wr/rd pointers wrap modulo depth.
  - count is FIFO_AW+1 bits.
  - Push when full: byte dropped, OVF set.
  - Simultaneous push and pop: both occur and count is unchanged.
  - Pop when empty: no effect.
- Register map (offset = addr - BASE_ADDR; hit = ce and offset < 8):
  - 0x0 DATA (read-only): [7:0] FIFO head byte, [8] valid (non-empty), other bits 0. Reads 0 when empty.
  - 0x4 STATUS: [0] non-empty, [1] full, [2] OVF (sticky), [3] PERR (sticky), [15:8] count zero-extended, other bits 0.
  - Offsets 0x1-0x3 alias 0x0; offsets 0x5-0x7 alias 0x4 (addr[2] selects).
  - data_o = 0 when hit=0.
- Pop rule: the CPU holds a read for multiple cycles, so pop on the rising edge of rd_sel = hit & ~we & ~addr[2]. Exactly one pop per read transaction, registered at the cycle after rd_sel rises. data_o shows the current head during the whole access, before the pop.
- Writes:
  - hit & we & addr[2] & sel[0]: W1C, where data_i[2] clears OVF and data_i[3] clears PERR.
  - Writes to DATA are ignored.
  - A set event and a clear of the same flag in one cycle: the set wins.
- irq = non-empty, registered.
- Reset mid-frame: FSM returns to IDLE and the FIFO empties immediately (asynchronous reset).

Optional Feature:
- Macro: KBD_BREAK_FILTER_EN.
- Defined: a 1-bit pending flag is kept.
  - Byte F0 is not pushed; it sets pending.
  - The next valid byte is discarded and clears pending.
  - Byte E0 is always pushed.
  - Result: only make codes and extension prefixes reach the FIFO.
  - Reset clears pending.
- Undefined: every valid byte, including F0 and the break code, is pushed. No pending logic is synthesised.

Test Plan:
- Send frame 0x1C with correct odd parity -> after CHECK, STATUS=0x0000_0101, irq=1. Read DATA held 4 cycles -> data_o=0x0000_011C, exactly one pop. Next STATUS read=0x0000_0000.
- Send 0x1C with bad parity -> FIFO unchanged, STATUS[3]=1. Write 0x8 to STATUS -> STATUS[3]=0.
- Send 17 valid bytes 0x01..0x11 with FIFO_AW=4 -> STATUS=0x0000_1007 (count 16, full, OVF, non-empty). 16 DATA reads return 0x101..0x110.
- Start bit plus 4 data bits, then stall TIMEOUT cycles, then a complete frame 0x2A -> only 0x2A is queued, count=1.
- Frame completes in the same cycle a DATA read rising edge occurs, with count=3 -> count remains 3 and head advances.
- Break filter: with KBD_BREAK_FILTER_EN, send 1C F0 1C -> FIFO holds only 0x1C, count=1. Without the macro -> 1C, F0, 1C, count=3.
